riscv_mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port synchronous RAM between the instruction-fetch path and the load/store data path of the RISC-V core. It grants one access at a time, drives the RAM port, and routes the one-cycle-latency read data back to the winning requester with a valid pulse. This lets the core be rebuilt as a multicycle design around a single memory port instead of a dual-port RAM.

---
 rtl/riscv_constants.sv | 17 +
 rtl/riscv_arb_starve_cnt.sv | 38 +++
 rtl/riscv_mem_arbiter.sv | 138 +++++++++++++
 tb/tb_riscv_mem_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_constants.sv
// Shared RISC-V core constants: state and grant encodings for the memory
// arbiter, kept in the same package as the decoder enums.
package riscv_constants;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESP_IF = 2'd1,
    RESP_D  = 2'd2
  } ARB_STATE;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_D    = 2'd2
  } ARB_GRANT;

endpackage

// File: rtl/riscv_arb_starve_cnt.sv
// Saturating count of data grants made while a fetch waits, with a compare
// against the limit. Only instantiated when RISCV_ARB_STARVE_GUARD_EN is set.
module riscv_arb_starve_cnt #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic x_reset,
  input  logic inc_i,
  input  logic clr_i,
  output logic hit_o
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Clear wins over increment; the count holds once it reaches the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != W'(LIMIT))) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (x_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = (cnt_q == W'(LIMIT));

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Two-requester arbiter (instruction fetch / load-store) in front of one
// single-port synchronous RAM. Data has priority over fetch; with
// RISCV_ARB_STARVE_GUARD_EN defined, a fetch is forced through after
// STARVE_LIMIT consecutive data grants made while it was waiting.
//
// state   | meaning
// IDLE    | arbitrate, drive the RAM port for the winner
// RESP_IF | RAM read data returning to the fetch path
// RESP_D  | RAM read data (or store ack) returning to the data path
module riscv_mem_arbiter
  import riscv_constants::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                x_reset,
  input  logic                if_req_valid,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_req_ready,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_resp_data,
  input  logic                d_req_valid,
  input  logic                d_req_we,
  input  logic [ADDR_W-1:0]   d_req_addr,
  input  logic [DATA_W-1:0]   d_req_wdata,
  input  logic [DATA_W/8-1:0] d_req_wstrb,
  output logic                d_req_ready,
  output logic                d_resp_valid,
  output logic [DATA_W-1:0]   d_resp_data,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata
);

  ARB_STATE state_q, state_d;
  logic     store_q, store_d;
  ARB_GRANT gnt;
  logic     starve_hit;

`ifdef RISCV_ARB_STARVE_GUARD_EN
  riscv_arb_starve_cnt #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .clk     (clk),
    .x_reset (x_reset),
    .inc_i   ((gnt == GNT_D) && if_req_valid),
    .clr_i   ((gnt == GNT_IF) || !if_req_valid),
    .hit_o   (starve_hit)
  );
`else
  // Strict data priority: the limit has no effect in this build.
  logic unused_starve_limit;
  assign unused_starve_limit = ^STARVE_LIMIT;
  assign starve_hit          = 1'b0;
`endif

  // Grant decision: only in IDLE and never while reset is asserted, so
  // every output is quiet during reset regardless of the registered state.
  always_comb begin
    gnt = GNT_NONE;
    if ((state_q == IDLE) && !x_reset) begin
      if (d_req_valid && !(starve_hit && if_req_valid)) begin
        gnt = GNT_D;
      end else if (if_req_valid) begin
        gnt = GNT_IF;
      end
    end
  end

  // Next state, RAM port mux and response routing.
  always_comb begin
    state_d       = IDLE;
    store_d       = 1'b0;
    if_req_ready  = 1'b0;
    d_req_ready   = 1'b0;
    if_resp_valid = 1'b0;
    if_resp_data  = '0;
    d_resp_valid  = 1'b0;
    d_resp_data   = '0;
    mem_en        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_wstrb     = '0;

    case (gnt)
      GNT_D: begin
        d_req_ready = 1'b1;
        mem_en      = 1'b1;
        mem_we      = d_req_we;
        mem_addr    = d_req_addr;
        mem_wdata   = d_req_we ? d_req_wdata : '0;
        mem_wstrb   = d_req_we ? d_req_wstrb : '0;
        store_d     = d_req_we;
        state_d     = RESP_D;
      end
      GNT_IF: begin
        if_req_ready = 1'b1;
        mem_en       = 1'b1;
        mem_addr     = if_req_addr;
        state_d      = RESP_IF;
      end
      default: ;
    endcase

    // A response pending across a reset is dropped.
    if (!x_reset) begin
      case (state_q)
        RESP_IF: begin
          if_resp_valid = 1'b1;
          if_resp_data  = mem_rdata;
        end
        RESP_D: begin
          d_resp_valid = 1'b1;
          d_resp_data  = store_q ? '0 : mem_rdata;
        end
        default: ;
      endcase
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (x_reset) begin
      state_q <= IDLE;
      store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter with a behavioural single-port RAM.
module tb_riscv_mem_arbiter;

  logic        clk = 1'b0;
  logic        x_reset;
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_req_ready;
  logic        if_resp_valid;
  logic [31:0] if_resp_data;
  logic        d_req_valid;
  logic        d_req_we;
  logic [31:0] d_req_addr;
  logic [31:0] d_req_wdata;
  logic [3:0]  d_req_wstrb;
  logic        d_req_ready;
  logic        d_resp_valid;
  logic [31:0] d_resp_data;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  logic        preload;
  logic [31:0] ram [0:255];

  always #5 clk = ~clk;

  riscv_mem_arbiter #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .STARVE_LIMIT (4)
  ) dut (
    .clk           (clk),
    .x_reset       (x_reset),
    .if_req_valid  (if_req_valid),
    .if_req_addr   (if_req_addr),
    .if_req_ready  (if_req_ready),
    .if_resp_valid (if_resp_valid),
    .if_resp_data  (if_resp_data),
    .d_req_valid   (d_req_valid),
    .d_req_we      (d_req_we),
    .d_req_addr    (d_req_addr),
    .d_req_wdata   (d_req_wdata),
    .d_req_wstrb   (d_req_wstrb),
    .d_req_ready   (d_req_ready),
    .d_resp_valid  (d_resp_valid),
    .d_resp_data   (d_resp_data),
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .mem_rdata     (mem_rdata)
  );

  // Synchronous RAM, word-indexed by addr[9:2], one-cycle read latency.
  always @(posedge clk) begin
    if (preload) begin
      ram[8'h04] <= 32'h0050_0093;
      ram[8'h08] <= 32'h0000_0013;
      ram[8'h40] <= 32'hDEAD_BEEF;
      ram[8'h41] <= 32'h1122_3344;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_wstrb[b]) ram[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
      end else begin
        mem_rdata <= ram[mem_addr[9:2]];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [5:0] exp_d;
  logic [5:0] exp_if;
  logic       was_if;

  initial begin
    preload      = 1'b1;
    mem_rdata    = '0;
    x_reset      = 1'b1;
    if_req_valid = 1'b1;
    if_req_addr  = 32'h20;
    d_req_valid  = 1'b1;
    d_req_we     = 1'b0;
    d_req_addr   = 32'h100;
    d_req_wdata  = '0;
    d_req_wstrb  = '0;

    // Reset held 3 cycles with both requesters valid.
    repeat (3) begin
      @(posedge clk); #2;
      chk("rst_d_ready",  32'(d_req_ready), 32'd0);
      chk("rst_if_ready", 32'(if_req_ready), 32'd0);
      chk("rst_mem_en",   32'({mem_en, mem_we}), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_resp",     32'({if_resp_valid, d_resp_valid}), 32'd0);
    end
    preload = 1'b0;

    // Release: collision, data wins.
    @(posedge clk); #1; x_reset = 1'b0; #1;
    chk("col_d_ready",  32'(d_req_ready), 32'd1);
    chk("col_if_ready", 32'(if_req_ready), 32'd0);
    chk("col_mem_en",   32'(mem_en), 32'd1);
    chk("col_mem_addr", mem_addr, 32'h100);
    @(posedge clk); #1; d_req_valid = 1'b0; #1;
    chk("col_d_resp_v",  32'(d_resp_valid), 32'd1);
    chk("col_d_resp",    d_resp_data, 32'hDEAD_BEEF);
    chk("col_resp_rdy",  32'({if_req_ready, d_req_ready, mem_en}), 32'd0);
    @(posedge clk); #2;
    chk("col_if_gnt",    32'(if_req_ready), 32'd1);
    chk("col_if_addr",   mem_addr, 32'h20);
    @(posedge clk); #1; if_req_valid = 1'b0; #1;
    chk("col_if_resp_v", 32'({if_resp_valid, d_resp_valid}), 32'b10);
    chk("col_if_resp",   if_resp_data, 32'h0000_0013);

    // Fetch only.
    @(posedge clk); #1; if_req_valid = 1'b1; if_req_addr = 32'h10; #1;
    chk("f_ready",  32'({if_req_ready, d_req_ready}), 32'b10);
    chk("f_mem",    32'({mem_en, mem_we, mem_wstrb}), 32'b100000);
    chk("f_addr",   mem_addr, 32'h10);
    @(posedge clk); #1; if_req_valid = 1'b0; #1;
    chk("f_resp_v", 32'({if_resp_valid, d_resp_valid}), 32'b10);
    chk("f_resp",   if_resp_data, 32'h0050_0093);
    chk("f_d_data", d_resp_data, 32'd0);
    @(posedge clk); #2;
    chk("idle_mem", 32'({mem_en, if_resp_valid}), 32'd0);
    chk("idle_addr", mem_addr, 32'd0);
    chk("idle_if_data", if_resp_data, 32'd0);

    // Store one byte lane.
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'h104;
    d_req_wdata = 32'h0000_AB00; d_req_wstrb = 4'b0010; #1;
    chk("st_ready", 32'(d_req_ready), 32'd1);
    chk("st_we_strb", 32'({mem_en, mem_we, mem_wstrb}), 32'b110010);
    chk("st_addr",  mem_addr, 32'h104);
    chk("st_wdata", mem_wdata, 32'h0000_AB00);
    @(posedge clk); #1; d_req_valid = 1'b0; d_req_we = 1'b0; d_req_wstrb = '0; #1;
    chk("st_ack_v", 32'(d_resp_valid), 32'd1);
    chk("st_ack_data", d_resp_data, 32'd0);
    @(posedge clk); #1; d_req_valid = 1'b1; #1;
    chk("rb_ready", 32'(d_req_ready), 32'd1);
    chk("rb_strb",  32'({mem_we, mem_wstrb}), 32'd0);
    @(posedge clk); #1; d_req_valid = 1'b0; #1;
    chk("rb_data",  d_resp_data, 32'h1122_AB44);

    // Reset in the RESP_D cycle.
    @(posedge clk); #1; d_req_valid = 1'b1; d_req_addr = 32'h100; #1;
    chk("mr_ready", 32'(d_req_ready), 32'd1);
    @(posedge clk); #1; d_req_valid = 1'b0; x_reset = 1'b1; #1;
    chk("mr_resp_v0", 32'(d_resp_valid), 32'd0);
    chk("mr_resp_d0", d_resp_data, 32'd0);
    @(posedge clk); #1; x_reset = 1'b0; #1;
    chk("mr_resp_v1", 32'({d_resp_valid, mem_en}), 32'd0);
    if_req_valid = 1'b1; if_req_addr = 32'h10; #1;
    chk("mr_idle_gnt", 32'(if_req_ready), 32'd1);
    @(posedge clk); #1; if_req_valid = 1'b0; #1;
    chk("mr_if_resp", if_resp_data, 32'h0050_0093);

    // Continuous data traffic with a waiting fetch.
`ifdef RISCV_ARB_STARVE_GUARD_EN
    exp_d  = 6'b101111;
    exp_if = 6'b010000;
`else
    exp_d  = 6'b111111;
    exp_if = 6'b000000;
`endif
    @(posedge clk); #1;
    if_req_valid = 1'b1; if_req_addr = 32'h10;
    d_req_valid  = 1'b1; d_req_addr  = 32'h100;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("sv_d_gnt%0d", k),  32'(d_req_ready),  32'(exp_d[k]));
      chk($sformatf("sv_if_gnt%0d", k), 32'(if_req_ready), 32'(exp_if[k]));
      was_if = if_req_ready;
      @(posedge clk); #1;
      if (was_if) if_req_valid = 1'b0;
      #1;
      chk($sformatf("sv_resp%0d", k), 32'({if_resp_valid, d_resp_valid}),
          32'({exp_if[k], exp_d[k]}));
      @(posedge clk); #1;
    end
    if_req_valid = 1'b0;
    d_req_valid  = 1'b0;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
